// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the encoder-tracking path that feeds the PWM steering loop.
// Holds the AS5600 angle constants and the tracker state encoding.
package pwm_ctrl_pkg;

    // AS5600 raw angle: 12 bits, one full turn = 4096 counts
    localparam int unsigned ANGLE_WIDTH = 12;
    localparam int unsigned ANGLE_MOD   = 4096;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        PENDING,
        UPDATE
    } track_state_e;

endpackage

// File: rtl/angle_tracker_if.sv
// Request/response handshake between the angle tracker and the AS5600 I2C reader.
//   get_data    : one-cycle read request (tracker -> reader)
//   angle_valid : one-cycle pulse, raw_angle valid (reader -> tracker)
//   raw_angle   : 12-bit encoder angle
// master = tracker side, slave = reader side.
interface angle_tracker_if;
    import pwm_ctrl_pkg::*;

    logic                   get_data;
    logic                   angle_valid;
    logic [ANGLE_WIDTH-1:0] raw_angle;

    modport master (
        output get_data,
        input  angle_valid,
        input  raw_angle
    );

    modport slave (
        input  get_data,
        output angle_valid,
        output raw_angle
    );

endinterface

// File: rtl/angle_unwrap.sv
// Unwrap datapath: turns successive 12-bit raw angles into a signed multi-turn
// position and a signed per-sample velocity.
//   clock, reset_n : clock, async active-low reset
//   load           : accept raw_angle this cycle
//   set_first      : next load re-seeds position from the raw angle
//   raw_angle      : encoder angle
//   position       : TURN_WIDTH+12 bit signed position (wraps, no saturation)
//   velocity       : 12-bit signed delta of the last accepted sample
module angle_unwrap
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned TURN_WIDTH = 8
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              load,
    input  logic                              set_first,
    input  logic [ANGLE_WIDTH-1:0]            raw_angle,
    output logic [TURN_WIDTH+ANGLE_WIDTH-1:0] position,
    output logic [ANGLE_WIDTH-1:0]            velocity
);
    localparam int unsigned PosWidth = TURN_WIDTH + ANGLE_WIDTH;

    logic [ANGLE_WIDTH-1:0] prev_q;
    logic [ANGLE_WIDTH-1:0] delta;
    logic [PosWidth-1:0]    pos_q, pos_d;
    logic [ANGLE_WIDTH-1:0] vel_q, vel_d;
    logic                   first_q;

    // Modulo-4096 difference read as signed; a half turn (0x800) lands on -2048.
    assign delta = raw_angle - prev_q;

    always_comb begin
        pos_d = pos_q;
        vel_d = vel_q;
        if (load) begin
            if (first_q) begin
                pos_d = PosWidth'(raw_angle);
                vel_d = '0;
            end else begin
                pos_d = pos_q + {{TURN_WIDTH{delta[ANGLE_WIDTH-1]}}, delta};
                vel_d = delta;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            pos_q   <= '0;
            vel_q   <= '0;
            first_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
            if (load) prev_q <= raw_angle;
            if (set_first) begin
                first_q <= 1'b1;
            end else if (load) begin
                first_q <= 1'b0;
            end
        end
    end

    assign position = pos_q;
    assign velocity = vel_q;

endmodule

// File: rtl/angle_tracker.sv
// Paces AS5600 reads, accepts returned angles and publishes unwrapped position,
// velocity and an encoder-stale flag to the PWM steering loop.
//   clock, reset_n : clock, async active-low reset
//   enable         : tracking active while high
//   rd             : handshake to the I2C reader (get_data / angle_valid / raw_angle)
//   position       : signed multi-turn position, encoder counts
//   velocity       : signed delta counts per accepted sample
//   pos_valid      : one-cycle pulse when position/velocity update
//   stale          : encoder stopped answering requests
module angle_tracker
    import pwm_ctrl_pkg::*;
#(
    parameter logic [15:0] SAMPLE_DIV   = 16'd50000,
    parameter int unsigned TURN_WIDTH   = 8,
    parameter int unsigned TIMEOUT_REQS = 3
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    angle_tracker_if.master                   rd,
    output logic [TURN_WIDTH+ANGLE_WIDTH-1:0] position,
    output logic [ANGLE_WIDTH-1:0]            velocity,
    output logic                              pos_valid,
    output logic                              stale
);
    localparam logic [3:0] MissMax = 4'(TIMEOUT_REQS);

    track_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [3:0]   miss_q, miss_d;
    logic         get_data_q;
    logic         stale_q, stale_d;
    logic         tick_seen_q;
    logic         tick, accept, miss_inc, timeout, set_first;

    assign tick      = enable && (cnt_q == SAMPLE_DIV - 16'd1);
    assign accept    = enable && (state_q == PENDING) && rd.angle_valid;
    assign miss_inc  = (state_q == PENDING) && tick && !rd.angle_valid;
    assign timeout   = miss_inc && (miss_q >= MissMax - 4'd1);
    assign set_first = (state_q == IDLE) || timeout;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!enable || tick) cnt_d = '0;
    end

    always_comb begin
        miss_d = miss_q;
        if (!enable || state_q == IDLE || accept) begin
            miss_d = '0;
        end else if (miss_inc && miss_q < MissMax) begin
            miss_d = miss_q + 4'd1;
        end
    end

    always_comb begin
        stale_d = stale_q;
        if (accept) begin
            stale_d = 1'b0;
        end else if (timeout) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            miss_q      <= '0;
            get_data_q  <= 1'b0;
            stale_q     <= 1'b0;
            tick_seen_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            get_data_q  <= tick;
            stale_q     <= stale_d;
            // A tick on the accepting cycle still owes a return to PENDING after UPDATE
            tick_seen_q <= accept && tick;
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      state_d = WAIT_TICK;
                WAIT_TICK: if (tick) state_d = PENDING;
                PENDING:   if (rd.angle_valid) state_d = UPDATE;
                UPDATE:    state_d = (tick || tick_seen_q) ? PENDING : WAIT_TICK;
                default:   state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        pos_valid = (state_q == UPDATE);
    end

    assign rd.get_data = get_data_q;
    assign stale       = stale_q;

    angle_unwrap #(
        .TURN_WIDTH(TURN_WIDTH)
    ) u_unwrap (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (accept),
        .set_first (set_first),
        .raw_angle (rd.raw_angle),
        .position  (position),
        .velocity  (velocity)
    );

endmodule

// File: tb/tb_angle_tracker.sv
// Directed, table-driven bench for angle_tracker. A main instance (SAMPLE_DIV 16,
// TURN_WIDTH 8, TIMEOUT_REQS 3) covers pacing, unwrap, timeout and corner timing;
// a second instance (SAMPLE_DIV 4, TURN_WIDTH 1) covers position rollover.
module tb_angle_tracker;
    import pwm_ctrl_pkg::*;

    typedef struct {
        logic [11:0] raw;
        logic [19:0] pos;
        logic [11:0] vel;
    } vec_t;

    typedef struct {
        logic [11:0] raw;
        logic [12:0] pos;
        logic [11:0] vel;
    } roll_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        enable2 = 1'b0;
    logic [19:0] position;
    logic [11:0] velocity;
    logic        pos_valid, stale;
    logic [12:0] position2;
    logic [11:0] velocity2;
    logic        pos_valid2, stale2;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[9];
    roll_t       rolls[6];

    angle_tracker_if bus ();
    angle_tracker_if bus2 ();

    always #5 clock = ~clock;

    angle_tracker #(
        .SAMPLE_DIV   (16'd16),
        .TURN_WIDTH   (8),
        .TIMEOUT_REQS (3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .rd        (bus),
        .position  (position),
        .velocity  (velocity),
        .pos_valid (pos_valid),
        .stale     (stale)
    );

    angle_tracker #(
        .SAMPLE_DIV   (16'd4),
        .TURN_WIDTH   (1),
        .TIMEOUT_REQS (3)
    ) dut2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable2),
        .rd        (bus2),
        .position  (position2),
        .velocity  (velocity2),
        .pos_valid (pos_valid2),
        .stale     (stale2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Step negedges until the main DUT's get_data is seen; waited = cycles stepped.
    task automatic wait_gd(output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!bus.get_data && waited < 40);
        if (!bus.get_data) begin
            checks++;
            errors++;
            $display("FAIL wait_get_data: no request within %0d cycles", waited);
        end
    endtask

    // Respond in the current cycle, then check the update on the next cycle.
    task automatic answer(input string name, input logic [11:0] raw,
                          input logic [19:0] exp_pos, input logic [11:0] exp_vel);
        bus.angle_valid = 1'b1;
        bus.raw_angle   = raw;
        @(negedge clock);
        bus.angle_valid = 1'b0;
        chk({name, "_pos_valid"}, pos_valid, 1);
        chk({name, "_position"}, position, exp_pos);
        chk({name, "_velocity"}, velocity, exp_vel);
        chk({name, "_stale"}, stale, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int cnt;
        logic [19:0] held;

        bus.angle_valid  = 1'b0;
        bus.raw_angle    = '0;
        bus2.angle_valid = 1'b0;
        bus2.raw_angle   = '0;

        vecs[0] = '{12'd100,  20'd100,    12'd0};
        vecs[1] = '{12'd4090, 20'(-6),    12'(-106)};
        vecs[2] = '{12'd5,    20'd5,      12'd11};
        vecs[3] = '{12'd4090, 20'(-6),    12'(-11)};
        vecs[4] = '{12'd2047, 20'(-2049), 12'(-2043)};
        vecs[5] = '{12'd0,    20'(-4096), 12'(-2047)};
        vecs[6] = '{12'd2048, 20'(-6144), 12'(-2048)};
        vecs[7] = '{12'd4095, 20'(-4097), 12'd2047};
        vecs[8] = '{12'd4094, 20'(-4098), 12'(-1)};

        rolls[0] = '{12'd0,    13'd0,    12'd0};
        rolls[1] = '{12'd2047, 13'd2047, 12'd2047};
        rolls[2] = '{12'd4094, 13'd4094, 12'd2047};
        rolls[3] = '{12'd2045, 13'd6141, 12'd2047};
        rolls[4] = '{12'd4092, 13'd8188, 12'd2047};
        rolls[5] = '{12'd2043, 13'd2043, 12'd2047};

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_get_data", bus.get_data, 0);
        chk("reset_pos_valid", pos_valid, 0);
        chk("reset_stale", stale, 0);
        chk("reset_position", position, 0);
        chk("reset_velocity", velocity, 0);
        reset_n = 1'b1;

        // First request lands SAMPLE_DIV cycles after enable
        @(negedge clock);
        enable = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (bus.get_data || pos_valid || stale || position != 0 || velocity != 0) cnt++;
        end
        chk("quiet_before_first_request", cnt, 0);
        @(negedge clock);
        chk("first_get_data_cycle16", bus.get_data, 1);

        // Table: unwrap across 0/4095 both ways and the half-turn boundary
        for (int i = 0; i < 9; i++) begin
            if (i > 0) wait_gd(w);
            answer($sformatf("vec%0d", i), vecs[i].raw, vecs[i].pos, vecs[i].vel);
            if (i == 0) chk("get_data_single_cycle", bus.get_data, 0);
        end

        // Timeout: one request plus three unanswered ticks
        wait_gd(w);
        for (int k = 1; k <= 3; k++) begin
            wait_gd(w);
            chk($sformatf("miss%0d_interval", k), w, 16);
            chk($sformatf("miss%0d_stale", k), stale, (k == 3) ? 1 : 0);
        end
        answer("after_timeout", 12'd2000, 20'd2000, 12'd0);

        // angle_valid coincident with tick
        wait_gd(w);
        repeat (15) @(negedge clock);
        bus.angle_valid = 1'b1;
        bus.raw_angle   = 12'd2100;
        @(negedge clock);
        bus.angle_valid = 1'b0;
        chk("coincident_pos_valid", pos_valid, 1);
        chk("coincident_new_request", bus.get_data, 1);
        chk("coincident_position", position, 2100);
        // UPDATE must return straight to PENDING, so an immediate answer is taken
        @(negedge clock);
        answer("coincident_follow", 12'd2200, 20'd2200, 12'd100);

        // Tick falling on the UPDATE cycle
        wait_gd(w);
        repeat (14) @(negedge clock);
        answer("tick_in_update", 12'd2300, 20'd2300, 12'd100);
        @(negedge clock);
        chk("tick_in_update_request", bus.get_data, 1);
        answer("tick_in_update_follow", 12'd2400, 20'd2400, 12'd100);

        // angle_valid while in WAIT_TICK is ignored
        @(negedge clock);
        bus.angle_valid = 1'b1;
        bus.raw_angle   = 12'd0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 2) bus.angle_valid = 1'b0;
            if (pos_valid) cnt++;
        end
        chk("wait_tick_ignore_pos_valid", cnt, 0);
        chk("wait_tick_ignore_position", position, 2400);

        // Disable mid-PENDING: no more requests, outputs hold
        wait_gd(w);
        enable = 1'b0;
        held = position;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            bus.angle_valid = (i % 5 == 1);
            bus.raw_angle   = 12'd1000;
            @(negedge clock);
            if (bus.get_data || pos_valid) cnt++;
        end
        bus.angle_valid = 1'b0;
        chk("disabled_no_pulses", cnt, 0);
        chk("disabled_position_hold", position, held);
        chk("disabled_velocity_hold", velocity, 100);

        // Re-enable: first flag re-armed, then reset mid-PENDING
        enable = 1'b1;
        wait_gd(w);
        chk("reenable_first_request_delay", w, 16);
        answer("reenable_first", 12'd300, 20'd300, 12'd0);
        wait_gd(w);
        reset_n = 1'b0;
        #1;
        chk("midreset_get_data", bus.get_data, 0);
        chk("midreset_position", position, 0);
        chk("midreset_velocity", velocity, 0);
        chk("midreset_pos_valid", pos_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.angle_valid = 1'b1;
        bus.raw_angle   = 12'd500;
        @(negedge clock);
        bus.angle_valid = 1'b0;
        @(negedge clock);
        chk("late_valid_ignored_pos_valid", pos_valid, 0);
        chk("late_valid_ignored_position", position, 0);
        enable = 1'b0;

        // Rollover on the 13-bit instance
        enable2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cnt = 0;
            do begin
                @(negedge clock);
                cnt++;
            end while (!bus2.get_data && cnt < 20);
            chk($sformatf("roll%0d_get_data", i), bus2.get_data, 1);
            bus2.angle_valid = 1'b1;
            bus2.raw_angle   = rolls[i].raw;
            @(negedge clock);
            bus2.angle_valid = 1'b0;
            chk($sformatf("roll%0d_pos_valid", i), pos_valid2, 1);
            chk($sformatf("roll%0d_position", i), position2, rolls[i].pos);
            chk($sformatf("roll%0d_velocity", i), velocity2, rolls[i].vel);
        end
        chk("roll_stale", stale2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
